// File: rtl/rails_pkg.sv
// rtl/rails_pkg.sv - shared states and constants for the rails arbiter
package rails_pkg;
  localparam int MAX_TRAINS = 10;
  localparam int TW = 4;

  typedef enum logic [2:0] {IDLE, NUM, DATA, PUSH, CHECK, DONE} state_t;
endpackage

// File: rtl/rails_stack.sv
// rtl/rails_stack.sv - LIFO station stack of train numbers
module rails_stack #(
  parameter int DEPTH = rails_pkg::MAX_TRAINS,
  parameter int W = rails_pkg::TW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);
  localparam int PW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] sp;

  assign empty = (sp == '0);
  assign full  = (sp == PW'(DEPTH));
  assign top   = empty ? '0 : mem[sp - PW'(1)];

  // stack pointer; reset or a per-job clear empties the stack
  always_ff @(posedge clk) begin
    if (reset || clr) sp <= '0;
    else if (push && !full) sp <= sp + PW'(1);
    else if (pop && !empty) sp <= sp - PW'(1);
  end

  // entry storage, written at the current pointer on push
  always_ff @(posedge clk) begin
    if (push && !full) mem[sp] <= din;
  end
endmodule

// File: rtl/rails_arb.sv
// rtl/rails_arb.sv - two-requester arbiter running stack-permutation jobs
module rails_arb #(
  parameter int MAX_TRAINS = rails_pkg::MAX_TRAINS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req,
  output logic [1:0]              gnt,
  input  logic [rails_pkg::TW-1:0] din1,
  input  logic [rails_pkg::TW-1:0] din2,
  input  logic [1:0]              din_vld,
  output logic [1:0]              din_rdy,
  output logic                    valid,
  output logic                    result,
  output logic                    result_id
);
  import rails_pkg::*;

  localparam logic [TW-1:0] MAXN = TW'(MAX_TRAINS);

  state_t        state, state_d;
  logic [1:0]    gnt_d, rdy_d;
  logic [TW-1:0] n_q, n_d, t_q, t_d, nxt_q, nxt_d, cnt_q, cnt_d;
  logic          fail_q, fail_d, last_q, last_d;
  logic          valid_d, result_d, id_d;
  logic          push, pop, clr, empty, full, acc;
  logic [TW-1:0] top, beat;

  assign beat = gnt[1] ? din2 : din1;
  assign acc  = |(din_vld & din_rdy);

  rails_stack #(.DEPTH(MAX_TRAINS), .W(TW)) u_stack (
    .clk(clk), .reset(reset), .clr(clr), .push(push), .pop(pop),
    .din(nxt_q), .top(top), .empty(empty), .full(full)
  );

  // state and registered outputs; last-granted pointer starts at ch2 so ch1 wins first
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE; gnt <= 2'b00; din_rdy <= 2'b00;
      valid <= 1'b0; result <= 1'b0; result_id <= 1'b0;
      n_q <= '0; t_q <= '0; nxt_q <= '0; cnt_q <= '0;
      fail_q <= 1'b0; last_q <= 1'b1;
    end else begin
      state <= state_d; gnt <= gnt_d; din_rdy <= rdy_d;
      valid <= valid_d; result <= result_d; result_id <= id_d;
      n_q <= n_d; t_q <= t_d; nxt_q <= nxt_d; cnt_q <= cnt_d;
      fail_q <= fail_d; last_q <= last_d;
    end
  end

  // next-state, datapath updates and stack commands
  always_comb begin
    state_d = state; gnt_d = gnt; n_d = n_q; t_d = t_q; nxt_d = nxt_q; cnt_d = cnt_q;
    fail_d = fail_q; last_d = last_q; valid_d = 1'b0; result_d = result; id_d = result_id;
    push = 1'b0; pop = 1'b0; clr = 1'b0;
    case (state)
      IDLE: begin
        clr = 1'b1;
        fail_d = 1'b0;
        if (|req) begin
          gnt_d = (req == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req;
          state_d = NUM;
        end
      end
      NUM: if (acc) begin
        n_d = beat; nxt_d = TW'(1); cnt_d = '0;
        if (beat == '0) state_d = DONE;
        else if (beat > MAXN) begin fail_d = 1'b1; state_d = DONE; end
        else state_d = DATA;
      end
      DATA: if (acc) begin
        t_d = beat;
        // once failed, beats are only counted so the stream drains
        if (fail_q || beat == '0 || beat > n_q) begin fail_d = 1'b1; state_d = CHECK; end
        else if (nxt_q <= beat) state_d = PUSH;
        else state_d = CHECK;
      end
      PUSH: begin
        push = !full;
        nxt_d = nxt_q + TW'(1);
        if (nxt_q == t_q) state_d = CHECK;
      end
      CHECK: begin
        if (!fail_q) begin
          if (!empty && top == t_q) pop = 1'b1;
          else fail_d = 1'b1;
        end
        cnt_d = cnt_q + TW'(1);
        state_d = (cnt_d == n_q) ? DONE : DATA;
      end
      DONE: begin
        state_d = IDLE; gnt_d = 2'b00; last_d = gnt[1];
      end
      default: state_d = IDLE;
    endcase
    if (state_d == DONE && state != DONE) begin
      valid_d = 1'b1; result_d = !fail_d; id_d = gnt[1];
    end
    rdy_d = (state_d == NUM || state_d == DATA) ? gnt_d : 2'b00;
  end
endmodule

// File: doc/rails_arb.md
RAILS_ARB -- requirements
Module: rails_arb

Interface
REQ-001 Parameter: MAX_TRAINS, default 10, maximum trains per job; the stack depth equals this value.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req  in  2  per-requester job request (bit0 = ch1, bit1 = ch2), held high until the requester sees gnt.
REQ-005 gnt  out  2  one-hot grant, held for the whole job.
REQ-006 din1, din2  in  4 each  requester beat data: first beat is train count N, following beats are departure targets.
REQ-007 din_vld  in  2  per-channel beat valid.
REQ-008 din_rdy  out  2  per-channel beat ready; a beat is accepted when vld and rdy are both high.
REQ-009 valid  out  1  one-cycle job-complete pulse.
REQ-010 result  out  1  1 = departure order achievable through the station stack; 0 = not achievable.
REQ-011 result_id  out  1  0 = ch1 job, 1 = ch2 job; meaningful only while valid is high.

Function
REQ-012 The block shall run one job at a time on a single shared station stack; the stack is empty at the start of every job.
REQ-013 States shall be IDLE, NUM, DATA, PUSH, CHECK, DONE.
REQ-014 IDLE, req nonzero: the block shall grant the next cycle, set gnt one-hot, and go to NUM.
REQ-015 If both req bits are high, the requester not granted last shall win (round-robin); after reset ch1 shall win first.
REQ-016 NUM: din_rdy of the granted channel shall be 1; on accept, latch N, set next_in=1 and cnt=0, and go to DATA.
REQ-017 NUM with N=0: go to DONE with result=1; N>MAX_TRAINS: go to DONE with result=0; no data beats are consumed in either case.
REQ-018 DATA: din_rdy of the granted channel shall be 1; on accept, latch target t.
REQ-019 DATA after latching t: if t is 0 or t>N, set fail; otherwise go to PUSH if next_in<=t, else go to CHECK.
REQ-020 PUSH: push next_in and increment next_in, one push per cycle, while next_in<=t; then go to CHECK.
REQ-021 CHECK, stack nonempty and top==t: pop.
REQ-022 CHECK, otherwise: set fail.
REQ-023 CHECK: increment cnt; go to DONE if cnt==N, else go to DATA.
REQ-024 Once fail is set, the block shall perform no further stack operations but shall still accept all remaining beats until cnt==N, so the requester's stream is drained.
REQ-025 DONE: valid=1 for exactly one cycle, result=!fail (or the value forced by REQ-017), result_id=granted channel.
REQ-026 DONE: gnt shall go to 0 the following cycle, the last-granted pointer shall update, and the state shall return to IDLE.
REQ-027 din_rdy shall be 0 in IDLE, PUSH, CHECK and DONE, and always 0 on the non-granted channel.
REQ-028 gnt and din_rdy shall be registered outputs; at most one gnt bit is high at any time.
REQ-029 Arithmetic is 4-bit unsigned; next_in never exceeds N+1 <= 11, so no wrap occurs.
REQ-030 The stack never overflows: push count is at most N.
REQ-031 A req asserted or changed mid-job shall be ignored until IDLE.

Reset
REQ-032 On reset: state=IDLE, gnt=0, din_rdy=0, valid=0, result=0, result_id=0, stack empty, fail=0, last-granted pointer=ch2.
REQ-033 Reset mid-job shall abort the job with no valid pulse; the next cycle shall be IDLE with gnt=0.

Structure
REQ-034 Package rails_pkg shall hold the state enum, MAX_TRAINS, and the 4-bit train-number width constant.
REQ-035 Stack shall be sub-module rails_stack (push, pop, top, empty, full; depth MAX_TRAINS, 4-bit entries, synchronous reset clears the pointer).

Verification
REQ-036 Pass case: ch1, N=5, targets 5,4,3,2,1 -> valid=1, result=1, result_id=0; 5 PUSH cycles precede the first CHECK.
REQ-037 Fail case: ch1, N=5, targets 5,4,1,2,3 -> beat 3 fails (top=3); all 5 beats accepted; result=0.
REQ-038 Arbitration: req=11 right after reset -> gnt=01 first job; gnt=10 next job; with req held at 11, grants alternate.
REQ-039 Range: N=0 -> result=1; N=11 -> result=0; in both, valid follows the number beat by one cycle and no data beats are taken.
REQ-040 Duplicate/out-of-range targets: N=3, targets 1,1,2 -> result=0; N=3, target 0 -> fail on beat 1.
REQ-041 Reset asserted during PUSH of a ch2 job -> no valid pulse, gnt=00, stack empty; the next req=10 job completes correctly.
